// File: rtl/accum_seq_pkg.sv
// accum_seq_pkg: shared state encoding, command layout and default widths
// for the accumulator sequence driver.
package accum_seq_pkg;
    localparam int DW_DEF  = 32;
    localparam int CW_DEF  = 16;
    localparam int GW_DEF  = 4;
    localparam int ECW_DEF = 16;

    typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DW_DEF-1:0] start;
        logic [DW_DEF-1:0] step;
        logic [CW_DEF-1:0] count;
        logic [GW_DEF-1:0] gap;
        logic              clear_first;
    } cmd_t;
endpackage

// File: rtl/accum_seq_checker.sv
// accum_seq_checker: reference accumulator model, check pipe, comparator,
// saturating error counter and first-mismatch capture.
module accum_seq_checker
    import accum_seq_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int ECW = ECW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [DW-1:0]  data,
    input  logic           enable,
    input  logic           clear,
    input  logic [DW-1:0]  accum,
    output logic           empty,
    output logic           err_flag,
    output logic [ECW-1:0] err_count,
    output logic [DW-1:0]  mis_exp,
    output logic [DW-1:0]  mis_obs
);
    logic [DW-1:0]  model_q, model_d, mis_exp_q, mis_exp_d, mis_obs_q, mis_obs_d;
    logic [ECW-1:0] cnt_q, cnt_d;
    logic [1:0]     vp_q, vp_d;
    logic           flag_q, flag_d, mismatch;

    // vp_q[0] marks the edge after the model/DUT update, where accum is compared
    always_comb begin
        mismatch  = vp_q[0] && (accum != model_q);
        model_d   = clear ? '0 : enable ? model_q + data : model_q;
        vp_d      = {vp_q[0], enable | clear};
        cnt_d     = (mismatch && !(&cnt_q)) ? cnt_q + ECW'(1) : cnt_q;
        flag_d    = flag_q | mismatch;
        mis_exp_d = (mismatch && !flag_q) ? model_q : mis_exp_q;
        mis_obs_d = (mismatch && !flag_q) ? accum : mis_obs_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            model_q   <= '0;
            vp_q      <= '0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            mis_exp_q <= '0;
            mis_obs_q <= '0;
        end else begin
            model_q   <= model_d;
            vp_q      <= vp_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            mis_exp_q <= mis_exp_d;
            mis_obs_q <= mis_obs_d;
        end
    end

    assign empty     = !enable && !clear && (vp_q == 2'b00);
    assign err_flag  = flag_q;
    assign err_count = cnt_q;
    assign mis_exp   = mis_exp_q;
    assign mis_obs   = mis_obs_q;
endmodule

// File: rtl/accum_seq_driver.sv
// accum_seq_driver: accepts burst commands, drives data/enable/clear into an
// accumulator and self-checks every returned accum value.
module accum_seq_driver
    import accum_seq_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int CW  = CW_DEF,
    parameter int GW  = GW_DEF,
    parameter int ECW = ECW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [DW-1:0]  cmd_start,
    input  logic [DW-1:0]  cmd_step,
    input  logic [CW-1:0]  cmd_count,
    input  logic [GW-1:0]  cmd_gap,
    input  logic           cmd_clear_first,
    output logic [DW-1:0]  data,
    output logic           enable,
    output logic           clear,
    input  logic [DW-1:0]  accum,
    output logic           done,
    output logic           busy,
    output logic           err_flag,
    output logic [ECW-1:0] err_count,
    output logic [DW-1:0]  mis_exp,
    output logic [DW-1:0]  mis_obs
);
    state_t        state_q, state_d;
    logic [DW-1:0] cur_q, cur_d, step_q, step_d, data_q, data_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic          enable_q, enable_d, clear_q, clear_d, done_q, done_d, ready_q, ready_d;
    logic          empty;

    // Outputs are registered, so each state computes what to drive next cycle;
    // enable_q is high exactly in RUN cycles with gcnt_q == 0.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        step_d   = step_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        gcnt_d   = gcnt_q;
        data_d   = data_q;
        enable_d = 1'b0;
        clear_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid && ready_q) begin
                cur_d    = cmd_start;
                step_d   = cmd_step;
                rem_d    = cmd_count;
                gap_d    = cmd_gap;
                gcnt_d   = '0;
                data_d   = cmd_start;
                clear_d  = cmd_clear_first;
                enable_d = !cmd_clear_first && (cmd_count != '0);
                state_d  = cmd_clear_first ? CLR : (cmd_count == '0) ? DRAIN : RUN;
            end
            CLR: begin
                enable_d = rem_q != '0;
                state_d  = (rem_q == '0) ? DRAIN : RUN;
            end
            RUN: if (gcnt_q == '0) begin
                rem_d = rem_q - CW'(1);
                cur_d = cur_q + step_q;
                if (rem_q == CW'(1)) state_d = DRAIN;
                else if (gap_q == '0) begin
                    enable_d = 1'b1;
                    data_d   = cur_q + step_q;
                end else gcnt_d = gap_q;
            end else begin
                gcnt_d   = gcnt_q - GW'(1);
                enable_d = gcnt_q == GW'(1);
                data_d   = (gcnt_q == GW'(1)) ? cur_q : data_q;
            end
            DRAIN: if (empty) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        endcase
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            step_q   <= '0;
            rem_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            data_q   <= '0;
            enable_q <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            step_q   <= step_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            data_q   <= data_d;
            enable_q <= enable_d;
            clear_q  <= clear_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    accum_seq_checker #(.DW(DW), .ECW(ECW)) u_chk (
        .clk      (clk),
        .reset    (reset),
        .data     (data_q),
        .enable   (enable_q),
        .clear    (clear_q),
        .accum    (accum),
        .empty    (empty),
        .err_flag (err_flag),
        .err_count(err_count),
        .mis_exp  (mis_exp),
        .mis_obs  (mis_obs)
    );

    assign cmd_ready = ready_q;
    assign busy      = !ready_q;
    assign data      = data_q;
    assign enable    = enable_q;
    assign clear     = clear_q;
    assign done      = done_q;
endmodule

// File: tb/tb_accum_seq_driver.sv
// tb_accum_seq_driver: directed bursts against a behavioural accumulator
// with optional fault injection on beat 2.
module tb_accum_seq_driver;
    import accum_seq_pkg::*;

    localparam int DW = 32, CW = 16, GW = 4, ECW = 16;

    logic           clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_clear_first = 1'b0;
    logic [DW-1:0]  cmd_start = '0, cmd_step = '0, data, accum, mis_exp, mis_obs;
    logic [CW-1:0]  cmd_count = '0;
    logic [GW-1:0]  cmd_gap = '0;
    logic           cmd_ready, enable, clear, done, busy, err_flag;
    logic [ECW-1:0] err_count;

    int ncmp = 0, nfail = 0;
    int n_en, n_clr, n_done, n_both, cyc, clr_cyc;
    int en_cyc[16];
    logic [DW-1:0] en_data[16];
    logic busy1;
    bit inj = 1'b0;
    int beat_no;

    always #5 clk = ~clk;

    accum_seq_driver #(.DW(DW), .CW(CW), .GW(GW), .ECW(ECW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_step(cmd_step), .cmd_count(cmd_count),
        .cmd_gap(cmd_gap), .cmd_clear_first(cmd_clear_first),
        .data(data), .enable(enable), .clear(clear), .accum(accum),
        .done(done), .busy(busy), .err_flag(err_flag), .err_count(err_count),
        .mis_exp(mis_exp), .mis_obs(mis_obs)
    );

    // Accumulator under test; inj adds +1 to the second beat after a clear
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            accum   <= '0;
            beat_no <= 0;
        end else if (clear) begin
            accum   <= '0;
            beat_no <= 0;
        end else if (enable) begin
            accum   <= accum + data + ((inj && beat_no == 1) ? 32'd1 : 32'd0);
            beat_no <= beat_no + 1;
        end
    end

    function automatic cmd_t mk(input logic [DW-1:0] s, input logic [DW-1:0] st,
                                input logic [CW-1:0] n, input logic [GW-1:0] g, input logic cf);
        cmd_t c;
        c.start = s; c.step = st; c.count = n; c.gap = g; c.clear_first = cf;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input cmd_t c, input int budget, input int stop_at_en);
        @(negedge clk);
        cmd_start = c.start; cmd_step = c.step; cmd_count = c.count;
        cmd_gap = c.gap; cmd_clear_first = c.clear_first; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_en = 0; n_clr = 0; n_done = 0; n_both = 0; cyc = 0; clr_cyc = -1; busy1 = 1'b0;
        while (n_done == 0 && cyc < budget && !(stop_at_en > 0 && n_en >= stop_at_en)) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = busy && !cmd_ready;
            if (enable && n_en < 16) begin
                en_cyc[n_en]  = cyc;
                en_data[n_en] = data;
            end
            if (enable) n_en++;
            if (clear) begin
                n_clr++;
                clr_cyc = cyc;
            end
            if (enable && clear) n_both++;
            if (done) n_done++;
        end
        if (stop_at_en == 0) begin
            chk("done_seen", 64'(n_done), 64'd1);
            chk("busy_during", 64'(busy1), 64'd1);
            chk("no_en_clr_overlap", 64'(n_both), 64'd0);
            @(negedge clk);
            chk("done_one_pulse", 64'(done), 64'd0);
            chk("ready_after", 64'(cmd_ready), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_clear", 64'(clear), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_err", 64'({err_flag, err_count, mis_exp, mis_obs}), 64'd0);
        reset = 1'b0;

        run(mk(32'd1, 32'd1, 16'd4, 4'd0, 1'b1), 100, 0);
        chk("basic_n_en", 64'(n_en), 64'd4);
        chk("basic_n_clr", 64'(n_clr), 64'd1);
        chk("basic_clr_before", 64'(clr_cyc), 64'(en_cyc[0] - 1));
        chk("basic_consecutive", 64'(en_cyc[3] - en_cyc[0]), 64'd3);
        for (int i = 0; i < 4; i++) chk("basic_data", 64'(en_data[i]), 64'(i + 1));
        chk("basic_accum", 64'(accum), 64'd10);
        chk("basic_err", 64'(err_count), 64'd0);

        run(mk(32'd2, 32'd0, 16'd1, 4'd0, 1'b0), 100, 0);
        chk("cont_n_clr", 64'(n_clr), 64'd0);
        chk("cont_n_en", 64'(n_en), 64'd1);
        chk("cont_accum", 64'(accum), 64'd12);
        chk("cont_err", 64'(err_count), 64'd0);

        run(mk(32'hFFFF_FFFF, 32'd0, 16'd2, 4'd0, 1'b1), 100, 0);
        chk("wrap_accum", 64'(accum), 64'hFFFF_FFFE);
        chk("wrap_err_flag", 64'(err_flag), 64'd0);

        run(mk(32'd5, 32'd0, 16'd3, 4'd2, 1'b1), 100, 0);
        chk("gap_n_en", 64'(n_en), 64'd3);
        chk("gap_spacing1", 64'(en_cyc[1] - en_cyc[0]), 64'd3);
        chk("gap_spacing2", 64'(en_cyc[2] - en_cyc[1]), 64'd3);
        chk("gap_hold_data", 64'(en_data[2]), 64'd5);
        chk("gap_accum", 64'(accum), 64'd15);
        chk("gap_err", 64'(err_count), 64'd0);

        run(mk(32'd7, 32'd1, 16'd0, 4'd0, 1'b0), 10, 0);
        chk("zero_fast", 64'(cyc <= 3), 64'd1);
        chk("zero_n_en", 64'(n_en), 64'd0);
        chk("zero_n_clr", 64'(n_clr), 64'd0);
        chk("zero_accum", 64'(accum), 64'd15);

        inj = 1'b1;
        run(mk(32'd1, 32'd1, 16'd4, 4'd0, 1'b1), 100, 0);
        inj = 1'b0;
        chk("inj_err_count", 64'(err_count), 64'd3);
        chk("inj_err_flag", 64'(err_flag), 64'd1);
        chk("inj_mis_exp", 64'(mis_exp), 64'd3);
        chk("inj_mis_obs", 64'(mis_obs), 64'd4);

        run(mk(32'd1, 32'd1, 16'd1, 4'd0, 1'b1), 100, 0);
        chk("sticky_flag", 64'(err_flag), 64'd1);
        chk("sticky_count", 64'(err_count), 64'd3);
        chk("sticky_mis_exp", 64'(mis_exp), 64'd3);

        run(mk(32'd1, 32'd1, 16'd8, 4'd0, 1'b1), 100, 2);
        chk("mid_enable_before", 64'(enable), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_enable", 64'(enable), 64'd0);
        chk("mid_clear", 64'(clear), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_ready", 64'(cmd_ready), 64'd1);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_err", 64'({err_flag, err_count, mis_exp}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run(mk(32'd3, 32'd0, 16'd2, 4'd0, 1'b0), 100, 0);
        chk("post_rst_accum", 64'(accum), 64'd6);
        chk("post_rst_err", 64'(err_count), 64'd0);
        chk("post_rst_flag", 64'(err_flag), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
